bytecode_fetch: RTL and testbench



---
 rtl/bytecode_fetch_pkg.sv | 12 +
 rtl/bytecode_fetch_byte_fifo.sv | 59 +++++
 rtl/bytecode_fetch.sv | 136 +++++++++++++
 tb/tb_bytecode_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytecode_fetch_pkg.sv
// rtl/bytecode_fetch_pkg.sv - shared FSM encodings for the bytecode fetch unit
package bytecode_fetch_pkg;

  localparam int FS_W = 2;

  typedef enum logic [FS_W-1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2
  } fs_e;

endpackage

// File: rtl/bytecode_fetch_byte_fifo.sv
// rtl/bytecode_fetch_byte_fifo.sv - byte-wide prefetch FIFO with flush
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic [CW-1:0] count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Full/empty guards make overflow and underflow requests harmless no-ops.
  assign w_push = push & (r_count != CW'(DEPTH));
  assign w_pop  = pop & (r_count != '0);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); flush empties in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;

endmodule

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - bytecode program counter, memory fetch FSM and prefetch buffer
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_adr,
  input  logic              advance,
  output logic [7:0]        iram_data,
  output logic              waiting,
  output logic [ADDR_W-1:0] pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fs_e               r_state;
  fs_e               w_state_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] r_adr;
  logic [ADDR_W-1:0] w_adr_nxt;
  logic [ADDR_W-1:0] r_fetch_adr;
  logic [ADDR_W-1:0] w_fetch_nxt;
  logic [ADDR_W-1:0] w_fetch_inc;
  logic [ADDR_W-1:0] r_pc;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_room;
  logic [7:0]        w_head;
  logic [CW-1:0]     w_count;

  // r_req doubles as the outstanding flag; stray acks are masked here.
  assign w_ack       = mem_ack & r_req;
  assign w_fetch_inc = r_fetch_adr + ADDR_W'(1);
  // Room for one more request counting the byte being acked now (registered count only).
  assign w_room      = (int'(w_count) + int'(w_ack)) < DEPTH;
  assign w_pop       = advance & ~waiting & ~jump;

  // Next-state, request and fetch-address decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_adr_nxt   = r_adr;
    w_fetch_nxt = r_fetch_adr;
    w_push      = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (jump) begin
          w_state_nxt = FS_FETCH;
          w_req_nxt   = 1'b1;
          w_adr_nxt   = jump_adr;
          w_fetch_nxt = jump_adr;
        end
      end
      FS_FETCH: begin
        if (jump) begin
          w_fetch_nxt = jump_adr;
          if (r_req && !mem_ack) begin
            w_state_nxt = FS_DRAIN;
          end else begin
            w_req_nxt = 1'b1;
            w_adr_nxt = jump_adr;
          end
        end else begin
          if (w_ack) begin
            w_push      = 1'b1;
            w_fetch_nxt = w_fetch_inc;
            w_req_nxt   = 1'b0;
          end
          if ((!r_req || w_ack) && w_room) begin
            w_req_nxt = 1'b1;
            w_adr_nxt = w_ack ? w_fetch_inc : r_fetch_adr;
          end
        end
      end
      FS_DRAIN: begin
        // Stale byte is discarded; the redirect target is requested right away.
        if (jump) w_fetch_nxt = jump_adr;
        if (w_ack) begin
          w_state_nxt = FS_FETCH;
          w_req_nxt   = 1'b1;
          w_adr_nxt   = jump ? jump_adr : r_fetch_adr;
        end
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // State, request port and program counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FS_IDLE;
      r_req       <= 1'b0;
      r_adr       <= '0;
      r_fetch_adr <= '0;
      r_pc        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_adr       <= w_adr_nxt;
      r_fetch_adr <= w_fetch_nxt;
      if (jump) begin
        r_pc <= jump_adr;
      end else if (w_pop) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (mem_data),
    .pop       (w_pop),
    .flush     (jump),
    .head      (w_head),
    .count     (w_count)
  );

  assign mem_req   = r_req;
  assign mem_adr   = r_adr;
  assign pc        = r_pc;
  assign waiting   = (w_count == '0);
  assign iram_data = waiting ? 8'h00 : w_head;

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - self-checking bench for bytecode_fetch
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [15:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        jump = 1'b0;
  logic [15:0] jump_adr = 16'h0000;
  logic        advance = 1'b0;
  logic [7:0]  iram_data;
  logic        waiting;
  logic [15:0] pc;

  logic [7:0]  mem_img [0:65535];
  logic [15:0] req_log [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          proto_err = 0;
  int          resp_lat = 1;
  bit          resp_rand = 1'b0;
  bit          force_ack = 1'b0;

  always #5 clk = ~clk;

  bytecode_fetch #(.ADDR_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_adr   (mem_adr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .jump      (jump),
    .jump_adr  (jump_adr),
    .advance   (advance),
    .iram_data (iram_data),
    .waiting   (waiting),
    .pc        (pc)
  );

  // Memory responder: one request at a time, programmable latency, stability check.
  initial begin : responder
    bit          busy;
    int          cnt;
    logic [15:0] b_adr;
    busy = 1'b0;
    cnt = 0;
    b_adr = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset) begin
        busy = 1'b0;
      end else begin
        if (busy && (!mem_req || mem_adr != b_adr)) proto_err++;
        if (!busy && mem_req) begin
          busy  = 1'b1;
          b_adr = mem_adr;
          cnt   = resp_rand ? int'($urandom_range(1, 4)) : resp_lat;
        end
        if (busy) begin
          if (cnt <= 1) begin
            mem_ack  = 1'b1;
            mem_data = mem_img[b_adr];
            busy     = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
      if (force_ack) begin
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (mem_req && (req_log.size() == 0 || mem_adr != req_log[req_log.size()-1]))
      req_log.push_back(mem_adr);
  endtask

  task automatic do_jump(input logic [15:0] a);
    jump = 1'b1;
    jump_adr = a;
    tick();
    jump = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_chk++; if (mem_adr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_adr got %h exp 0000", mem_adr); end
    n_chk++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", pc); end
    n_chk++; if (waiting !== 1'b1) begin n_fail++; $display("FAIL reset_waiting got %b exp 1", waiting); end
    n_chk++; if (iram_data !== 8'h00) begin n_fail++; $display("FAIL reset_iram got %h exp 00", iram_data); end
    reset = 1'b1;
    req_log.delete();
  endtask

  task automatic test_fill();
    resp_lat = 1;
    tick();
    do_jump(16'h0100);
    n_chk++;
    if (mem_req !== 1'b1 || mem_adr !== 16'h0100) begin
      n_fail++; $display("FAIL fill_first_req got req=%b adr=%h exp req=1 adr=0100", mem_req, mem_adr);
    end
    repeat (12) tick();
    n_chk++;
    if (req_log.size() != 4) begin
      n_fail++; $display("FAIL fill_req_count got %0d exp 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (req_log[i] !== 16'h0100 + 16'(i)) begin
          n_fail++; $display("FAIL fill_req_adr[%0d] got %h exp %h", i, req_log[i], 16'h0100 + 16'(i));
        end
      end
    end
    n_chk++; if (iram_data !== 8'hAB || waiting !== 1'b0) begin n_fail++; $display("FAIL fill_head got %h/w%b exp AB/w0", iram_data, waiting); end
    n_chk++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL fill_pc got %h exp 0100", pc); end
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_full_no_req got %b exp 0", mem_req); end
  endtask

  task automatic test_advance();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (iram_data !== mem_img[16'h0100 + 16'(i)] || pc !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL adv_byte[%0d] got %h@%h exp %h@%h", i, iram_data, pc,
                           mem_img[16'h0100 + 16'(i)], 16'h0100 + 16'(i));
      end
      advance = 1'b1;
      tick();
    end
    advance = 1'b0;
    n_chk++; if (pc !== 16'h0104) begin n_fail++; $display("FAIL adv_pc got %h exp 0104", pc); end
    n_chk++;
    if (req_log.size() < 5 || req_log[4] !== 16'h0104) begin
      n_fail++; $display("FAIL adv_resume got size %0d exp req 0104 at index 4", req_log.size());
    end
    n_chk++;
    if (waiting !== 1'b0 || iram_data !== mem_img[16'h0104]) begin
      n_fail++; $display("FAIL adv_new_head got %h/w%b exp %h/w0", iram_data, waiting, mem_img[16'h0104]);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [15:0] m_pc;
    bit w;
    m_pc = 16'h0104;
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (pc !== m_pc) begin n_fail++; $display("FAIL pp_pc[%0d] got %h exp %h", i, pc, m_pc); end
      if (!waiting) begin
        n_chk++;
        if (iram_data !== mem_img[m_pc]) begin
          n_fail++; $display("FAIL pp_byte[%0d] got %h exp %h", i, iram_data, mem_img[m_pc]);
        end
      end
      w = waiting;
      advance = 1'b1;
      tick();
      if (!w) m_pc = m_pc + 16'd1;
    end
    advance = 1'b0;
  endtask

  task automatic test_jump_drain();
    bit found;
    bit saw_ee;
    int idx;
    pulse_reset();
    resp_lat = 3;
    do_jump(16'h0100);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && mem_adr == 16'h0103) found = 1'b1;
      else tick();
    end
    n_chk++;
    if (!found) begin
      n_fail++; $display("FAIL drain_setup got no request to 0103 exp one within 40 cycles");
    end else begin
      do_jump(16'h0200);
      n_chk++;
      if (mem_req !== 1'b1 || mem_adr !== 16'h0103 || waiting !== 1'b1) begin
        n_fail++; $display("FAIL drain_hold got req=%b adr=%h w=%b exp 1/0103/1", mem_req, mem_adr, waiting);
      end
      saw_ee = 1'b0;
      for (int i = 0; i < 30 && waiting; i++) begin
        tick();
        if (!waiting && iram_data == 8'hEE) saw_ee = 1'b1;
      end
      n_chk++; if (waiting !== 1'b0) begin n_fail++; $display("FAIL drain_timeout got waiting=1 exp 0 within 30 cycles"); end
      n_chk++; if (saw_ee) begin n_fail++; $display("FAIL drain_stale_byte got EE exp never"); end
      n_chk++; if (iram_data !== 8'h5A || pc !== 16'h0200) begin n_fail++; $display("FAIL drain_target got %h@%h exp 5A@0200", iram_data, pc); end
      idx = -1;
      foreach (req_log[i]) if (req_log[i] == 16'h0103) idx = i;
      n_chk++;
      if (idx < 0 || idx + 1 >= req_log.size() || req_log[idx+1] !== 16'h0200) begin
        n_fail++; $display("FAIL drain_next_adr got idx=%0d size=%0d exp 0200 after 0103", idx, req_log.size());
      end
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    resp_lat = 1;
    do_jump(16'hFFFF);
    repeat (8) tick();
    n_chk++;
    if (req_log.size() < 2 || req_log[0] !== 16'hFFFF || req_log[1] !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_adr got size %0d exp FFFF then 0000", req_log.size());
    end
    n_chk++; if (pc !== 16'hFFFF || iram_data !== 8'h11) begin n_fail++; $display("FAIL wrap_head got %h@%h exp 11@FFFF", iram_data, pc); end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    n_chk++; if (pc !== 16'h0000 || iram_data !== 8'h22) begin n_fail++; $display("FAIL wrap_pc got %h@%h exp 22@0000", iram_data, pc); end
  endtask

  task automatic test_reset_mid();
    resp_lat = 6;
    do_jump(16'h0300);
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_outstanding got %b exp 1", mem_req); end
    reset = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || mem_adr !== 16'h0000 || pc !== 16'h0000 || waiting !== 1'b1 || iram_data !== 8'h00) begin
      n_fail++; $display("FAIL rmid_immediate got req=%b adr=%h pc=%h w=%b d=%h exp 0/0000/0000/1/00",
                         mem_req, mem_adr, pc, waiting, iram_data);
    end
    tick();
    reset = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (mem_req !== 1'b0 || waiting !== 1'b1 || iram_data !== 8'h00 || pc !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_late_ack got req=%b w=%b d=%h pc=%h exp 0/1/00/0000", mem_req, waiting, iram_data, pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] jadr;
    bit j;
    bit adv;
    bit w;
    int wc;
    pulse_reset();
    resp_rand = 1'b1;
    m_pc = 16'h0000;
    wc = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      n_chk++;
      if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc, m_pc); end
      n_chk++;
      if (!waiting && iram_data !== mem_img[m_pc]) begin
        n_fail++; $display("FAIL rnd_byte[%0d] got %h exp %h", i, iram_data, mem_img[m_pc]);
      end else if (waiting && iram_data !== 8'h00) begin
        n_fail++; $display("FAIL rnd_idle_data[%0d] got %h exp 00", i, iram_data);
      end
      if (i > 0 && waiting) wc++; else wc = 0;
      if (wc > 40) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_stall got waiting for %0d cycles exp under 40", wc);
        break;
      end
      j    = ($urandom_range(0, 29) == 0) || (i == 0);
      adv  = 1'($urandom_range(0, 1));
      jadr = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      w    = waiting;
      jump = j;
      jump_adr = jadr;
      advance = adv;
      if (j) m_pc = jadr;
      else if (adv && !w) m_pc = m_pc + 16'd1;
    end
    jump = 1'b0;
    advance = 1'b0;
    resp_rand = 1'b0;
  endtask

  task automatic test_protocol();
    n_chk++;
    if (proto_err != 0) begin n_fail++; $display("FAIL protocol_stability got %0d violations exp 0", proto_err); end
  endtask

  initial begin : main
    for (int a = 0; a < 65536; a++) mem_img[a] = 8'($urandom);
    mem_img[16'h0100] = 8'hAB;
    mem_img[16'h0101] = 8'h12;
    mem_img[16'h0102] = 8'hC4;
    mem_img[16'h0103] = 8'hEE;
    mem_img[16'h0200] = 8'h5A;
    mem_img[16'hFFFF] = 8'h11;
    mem_img[16'h0000] = 8'h22;
    mem_img[16'h0001] = 8'h33;
    test_reset();
    test_fill();
    test_advance();
    test_push_pop_same_cycle();
    test_jump_drain();
    test_wrap();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
